// File: rtl/t05_arb_pkg.sv
// t05_arb_pkg -- shared types for the SRAM arbiter slice.
//   arb_state_t : transaction FSM states (IDLE, ISSUE, WAIT_START, WAIT_END, DONE)
//   idx_width() : width of a client index; never below one bit so a
//                 single-client build still has a legal index vector.
package t05_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_END,
    DONE
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t05_rr_grant.sv
// t05_rr_grant -- combinational round-robin grant selection.
// Searches the request vector starting one position after the previously
// granted client and wrapping from NUM_CLIENTS-1 back to 0, so the client
// just served has the lowest priority on the next decision.
// Ports:
//   req         : per-client request vector
//   last        : index of the most recently granted client
//   grant       : one-hot grant (all zero when nobody requests)
//   grant_idx   : binary index of the granted client
//   grant_valid : at least one request is present
module t05_rr_grant
  import t05_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 6,
  parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  logic [IDX_W-1:0] cand_idx;

  // Walk the candidates in priority order; the first requester wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      cand_idx = IDX_W'((int'(last) + i) % NUM_CLIENTS);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid     = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// t05_sram_arbiter -- round-robin arbiter sharing one SRAM bus manager
// between NUM_CLIENTS requesting stages.
// A transaction is IDLE -> ISSUE -> WAIT_START -> WAIT_END -> DONE; the
// winner's command is latched at grant time and held until DONE.
// Optional build macro: T05_ARB_TIMEOUT_EN adds a wait-time watchdog that
// ends a stuck transaction with an err_o pulse instead of done_o.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_i/we_i             : per-client request (held until done) and write flag
//   addr_i/wdata_i/sel_i   : per-client command fields, packed client 0 at LSB
//   done_o/err_o           : one-cycle completion / timeout pulse to the owner
//   rdata_o                : read data latched at the end of a read
//   write_o/read_o         : one-cycle command strobe to the bus manager
//   addr_o/sel_o/data_o    : latched command fields to the bus manager
//   data_i/busy_i          : bus-manager read data and busy
module t05_sram_arbiter
  import t05_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 6,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CLIENTS-1:0]          req_i,
  input  logic [NUM_CLIENTS-1:0]          we_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0]   wdata_i,
  input  logic [NUM_CLIENTS*DATA_W/8-1:0] sel_i,
  output logic [NUM_CLIENTS-1:0]          done_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic [NUM_CLIENTS-1:0]          err_o,
  output logic                            write_o,
  output logic                            read_o,
  output logic [ADDR_W-1:0]               addr_o,
  output logic [DATA_W/8-1:0]             sel_o,
  output logic [DATA_W-1:0]               data_o,
  input  logic [DATA_W-1:0]               data_i,
  input  logic                            busy_i
);

  localparam int IDX_W = idx_width(NUM_CLIENTS);
  localparam int SEL_W = DATA_W / 8;

  arb_state_t state_q, state_d;

  // last_q doubles as the round-robin pointer and the current owner index.
  logic [IDX_W-1:0]       last_q;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [SEL_W-1:0]       sel_q;
  logic [DATA_W-1:0]      rdata_q;

  logic [NUM_CLIENTS-1:0] gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_valid;
  logic                   start;

  logic                   we_mux;
  logic [ADDR_W-1:0]      addr_mux;
  logic [DATA_W-1:0]      wdata_mux;
  logic [SEL_W-1:0]       sel_mux;

  logic                   timeout_hit;
  logic                   to_take;
  logic                   to_q;

  t05_rr_grant #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_rr_grant (
    .req        (req_i),
    .last       (last_q),
    .grant      (gnt),
    .grant_idx  (gnt_idx),
    .grant_valid(gnt_valid)
  );

  assign start = (state_q == IDLE) && gnt_valid;

  // One-hot select of the winning client's command fields.
  always_comb begin
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    sel_mux   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt[i]) begin
        we_mux    = we_i[i];
        addr_mux  = addr_i[i*ADDR_W +: ADDR_W];
        wdata_mux = wdata_i[i*DATA_W +: DATA_W];
        sel_mux   = sel_i[i*SEL_W +: SEL_W];
      end
    end
  end

`ifdef T05_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             in_wait;

  assign in_wait     = (state_q == WAIT_START) || (state_q == WAIT_END);
  assign timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  // A normal completion in the same cycle as the timeout wins.
  assign to_take     = timeout_hit && !((state_q == WAIT_END) && !busy_i);

  // Wait counter runs only while waiting on the bus manager; to_q marks the
  // transaction as timed out so DONE pulses err_o rather than done_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (in_wait) cnt_q <= cnt_q + CNT_W'(1);
      else         cnt_q <= '0;
      if (state_q == ISSUE) to_q <= 1'b0;
      else if (to_take)     to_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_take     = 1'b0;
  assign to_q        = 1'b0;
`endif

  // Next-state logic. ISSUE always spends exactly one cycle, so an early
  // busy_i still leaves one cycle in WAIT_START.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (gnt_valid) state_d = ISSUE;
      ISSUE:      state_d = WAIT_START;
      WAIT_START: begin
        if (timeout_hit) state_d = DONE;
        else if (busy_i) state_d = WAIT_END;
      end
      WAIT_END:   if (!busy_i || to_take) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Command strobes and owner pulses decode from the current state only.
  always_comb begin
    write_o = (state_q == ISSUE) && we_q;
    read_o  = (state_q == ISSUE) && !we_q;
    done_o  = '0;
    err_o   = '0;
    if (state_q == DONE) begin
      if (to_q) err_o[last_q]  = 1'b1;
      else      done_o[last_q] = 1'b1;
    end
  end

  // State register, grant pointer and command/read-data latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_CLIENTS - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        last_q  <= gnt_idx;
        we_q    <= we_mux;
        addr_q  <= addr_mux;
        wdata_q <= wdata_mux;
        sel_q   <= sel_mux;
      end
      if ((state_q == WAIT_END) && !busy_i && !we_q) rdata_q <= data_i;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = wdata_q;
  assign sel_o   = sel_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// tb_t05_sram_arbiter -- self-checking bench for t05_sram_arbiter.
// Directed table of single transactions, hand-written corner sequences
// (full round-robin lap, mid-transaction reset, dropped request, stuck
// busy), then a randomized run against a transaction-level model.
// Build macro T05_ARB_TIMEOUT_EN selects the timeout sequence.
module tb_t05_sram_arbiter;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_i;
  logic [N-1:0]      we_i;
  logic [N*AW-1:0]   addr_i;
  logic [N*DW-1:0]   wdata_i;
  logic [N*SW-1:0]   sel_i;
  logic [N-1:0]      done_o;
  logic [DW-1:0]     rdata_o;
  logic [N-1:0]      err_o;
  logic              write_o;
  logic              read_o;
  logic [AW-1:0]     addr_o;
  logic [SW-1:0]     sel_o;
  logic [DW-1:0]     data_o;
  logic [DW-1:0]     data_i;
  logic              busy_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  t05_sram_arbiter #(
    .NUM_CLIENTS(N),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .sel_i  (sel_i),
    .done_o (done_o),
    .rdata_o(rdata_o),
    .err_o  (err_o),
    .write_o(write_o),
    .read_o (read_o),
    .addr_o (addr_o),
    .sel_o  (sel_o),
    .data_o (data_o),
    .data_i (data_i),
    .busy_i (busy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something escapes the per-wait bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [N-1:0] req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   sel;
    int           d0;
    int           d1;
    logic [31:0]  rd;
    int           exp_client;
    int           exp_lat;
    logic [31:0]  exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic setClient(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    we_i[i]              = we;
    addr_i[i*AW +: AW]   = a;
    wdata_i[i*DW +: DW]  = d;
    sel_i[i*SW +: SW]    = s;
  endtask

  task automatic resetDut();
    rst_n   = 1'b0;
    req_i   = '0;
    busy_i  = 1'b0;
    data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_done",  done_o,  '0);
    checkOutput("rst_err",   err_o,   '0);
    checkOutput("rst_write", write_o, 1'b0);
    checkOutput("rst_read",  read_o,  1'b0);
    checkOutput("rst_addr",  addr_o,  '0);
    checkOutput("rst_rdata", rdata_o, '0);
    rst_n = 1'b1;
    waitCycle();
  endtask

  // Runs one transaction from an idle DUT, acting as the bus manager:
  // busy low for d0 cycles after ISSUE, high for d1 cycles, then low with
  // rd on data_i. Reports the served client, issue-to-done latency and
  // rdata_o seen with done_o.
  task automatic applyStimulus(input logic [N-1:0] req, input logic we_all,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input int d0, input int d1,
                               input logic [31:0] rd, input logic [N-1:0] drop_ws,
                               input bit hold, output int client, output int lat,
                               output logic [31:0] rdata_seen, output int issue_cyc);
    bit found;
    client = -1; lat = -1; rdata_seen = '0; issue_cyc = -1;
    for (int i = 0; i < N; i++) if (req[i]) setClient(i, we_all, addr, wdata, sel);
    req_i  = req;
    busy_i = 1'b0;
    found  = 0;
    for (int t = 0; t < 8 && !found; t++) begin
      waitCycle();
      if (write_o || read_o) found = 1;
    end
    if (!found) begin
      checkOutput("issue_seen", 0, 1);
      return;
    end
    issue_cyc = cyc;
    checkOutput("cmd_write", write_o, we_all);
    checkOutput("cmd_read",  read_o,  !we_all);
    checkOutput("cmd_addr",  addr_o,  addr);
    checkOutput("cmd_data",  data_o,  wdata);
    checkOutput("cmd_sel",   sel_o,   sel);
    busy_i = (d0 == 0);
    found  = 0;
    for (int j = 1; j <= 40 && !found; j++) begin
      waitCycle();
      if (done_o != '0 || err_o != '0) found = 1;
      else begin
        if (j == 1) req_i = req_i & ~drop_ws;
        busy_i = (j > d0) && (j <= d0 + d1);
        data_i = (j == d0 + d1 + 1) ? rd : $urandom;
      end
    end
    if (!found) begin
      checkOutput("done_seen", 0, 1);
      return;
    end
    lat = cyc - issue_cyc;
    for (int i = 0; i < N; i++) if (done_o[i]) client = i;
    rdata_seen = rdata_o;
    checkOutput("done_onehot",  $countones(done_o), 1);
    checkOutput("err_quiet",    err_o, '0);
    checkOutput("addr_hold",    addr_o, addr);
    checkOutput("strobe_single", {write_o, read_o}, 2'b00);
    busy_i = 1'b0;
    if (!hold) req_i = '0;
    waitCycle();
    checkOutput("done_single", done_o, '0);
  endtask

  function automatic int rrPick(input logic [N-1:0] req, input int last);
    for (int s = 1; s <= N; s++) begin
      int idx;
      idx = (last + s) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  initial begin
    int          client, lat, ic, prev_ic;
    logic [31:0] rds;
    int          seen[N];

    vecs[0] = '{6'b000100, 1'b1, 32'h40,       32'hDEADBEEF, 4'hF, 0, 3, 32'h0,      2, 5, 32'h0};
    vecs[1] = '{6'b000010, 1'b0, 32'h80,       32'h0,        4'hF, 1, 2, 32'h12345678, 1, 5, 32'h12345678};
    vecs[2] = '{6'b100001, 1'b1, 32'h1000,     32'h0BADF00D, 4'h3, 0, 1, 32'h0,      5, 3, 32'h12345678};
    vecs[3] = '{6'b100001, 1'b1, 32'h2000,     32'hCAFEBABE, 4'hC, 2, 1, 32'h0,      0, 5, 32'h12345678};
    vecs[4] = '{6'b110000, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h8, 0, 2, 32'hA5A5A5A5, 4, 4, 32'hA5A5A5A5};

    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; sel_i = '0;
    data_i = '0; busy_i = 1'b0; rst_n = 1'b0;

    $display("[TB] directed vector table");
    resetDut();
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].sel,
                    vecs[v].d0, vecs[v].d1, vecs[v].rd, '0, 1'b0, client, lat, rds, ic);
      checkOutput($sformatf("vec%0d_client", v), client, vecs[v].exp_client);
      checkOutput($sformatf("vec%0d_lat", v),    lat,    vecs[v].exp_lat);
      checkOutput($sformatf("vec%0d_rdata", v),  rds,    vecs[v].exp_rdata);
    end

    $display("[TB] full round-robin lap with all clients requesting");
    resetDut();
    foreach (seen[i]) seen[i] = 0;
    prev_ic = 0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus('1, k[0], 32'h100 * k, 32'h1111 * k, 4'hF, 0, 1, 32'h0, '0, 1'b1,
                    client, lat, rds, ic);
      checkOutput($sformatf("rr_order%0d", k), client, k % N);
      if (k > 0) checkOutput($sformatf("rr_spacing%0d", k), ic - prev_ic, 5);
      if (k < N && client >= 0 && client < N) seen[client]++;
      prev_ic = ic;
    end
    req_i = '0;
    for (int i = 0; i < N; i++) checkOutput($sformatf("rr_lap_count%0d", i), seen[i], 1);

    $display("[TB] reset during WAIT_END");
    resetDut();
    setClient(0, 1'b1, 32'h300, 32'h77, 4'hF);
    req_i  = 6'b000001;
    ic     = -1;
    for (int t = 0; t < 8 && ic < 0; t++) begin
      waitCycle();
      if (write_o) ic = cyc;
    end
    checkOutput("mr_issue_seen", ic >= 0, 1);
    busy_i = 1'b1;
    waitCycle();
    waitCycle();
    checkOutput("mr_addr_before", addr_o, 32'h300);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_write", write_o, 1'b0);
    checkOutput("mr_read",  read_o,  1'b0);
    checkOutput("mr_done",  done_o,  '0);
    checkOutput("mr_addr",  addr_o,  '0);
    checkOutput("mr_data",  data_o,  '0);
    busy_i = 1'b0;
    req_i  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycle();
    applyStimulus('1, 1'b0, 32'h500, 32'h0, 4'hF, 0, 1, 32'h9, '0, 1'b0, client, lat, rds, ic);
    checkOutput("mr_first_client", client, 0);

    $display("[TB] granted client drops its request in WAIT_START");
    resetDut();
    applyStimulus(6'b000011, 1'b0, 32'h600, 32'h0, 4'hF, 1, 1, 32'h55AA55AA, 6'b000001, 1'b1,
                  client, lat, rds, ic);
    checkOutput("drop_client", client, 0);
    checkOutput("drop_lat",    lat,    4);
    checkOutput("drop_rdata",  rds,    32'h55AA55AA);
    applyStimulus(6'b000010, 1'b1, 32'h700, 32'h42, 4'h1, 0, 1, 32'h0, '0, 1'b0,
                  client, lat, rds, ic);
    checkOutput("drop_next_client", client, 1);

`ifdef T05_ARB_TIMEOUT_EN
    $display("[TB] busy stuck high with timeout enabled");
    resetDut();
    setClient(3, 1'b1, 32'h800, 32'h1, 4'hF);
    req_i = 6'b001000;
    ic    = -1;
    for (int t = 0; t < 8 && ic < 0; t++) begin
      waitCycle();
      if (write_o) ic = cyc;
    end
    checkOutput("to_issue_seen", ic >= 0, 1);
    busy_i = 1'b1;
    lat    = -1;
    for (int t = 0; t < 30 && lat < 0; t++) begin
      waitCycle();
      if (err_o != '0 || done_o != '0) lat = cyc - ic;
    end
    checkOutput("to_err",  err_o,  6'b001000);
    checkOutput("to_done", done_o, '0);
    checkOutput("to_lat",  lat,    9);
    busy_i = 1'b0;
    req_i  = '0;
    waitCycle();
    checkOutput("to_err_single", err_o, '0);
`else
    $display("[TB] busy stuck high without timeout");
    resetDut();
    setClient(3, 1'b1, 32'h800, 32'h1, 4'hF);
    req_i  = 6'b001000;
    busy_i = 1'b1;
    lat    = 0;
    for (int t = 0; t < 40; t++) begin
      waitCycle();
      if (err_o != '0 || done_o != '0) lat++;
    end
    checkOutput("stuck_no_pulse", lat, 0);
`endif

    $display("[TB] randomized traffic against reference model");
    resetDut();
    begin
      logic [N-1:0] mreq;
      logic         m_we[N];
      logic [31:0]  m_addr[N];
      logic [31:0]  m_wd[N];
      logic [3:0]   m_sel[N];
      int           m_last, m_client, m_issue, m_done, m_d0, m_d1, m_idle_from, k;
      bit           m_txn;
      logic [31:0]  m_rdata, m_cap;
      logic [N-1:0] expd;

      mreq = '0; m_last = N - 1; m_txn = 0; m_client = 0;
      m_issue = 0; m_done = 0; m_d0 = 0; m_d1 = 0;
      m_idle_from = cyc; m_rdata = '0; m_cap = '0;
      for (int i = 0; i < N; i++) begin
        m_we[i] = 1'b0; m_addr[i] = '0; m_wd[i] = '0; m_sel[i] = '0;
      end

      for (int n = 0; n < 600; n++) begin
        waitCycle();
        k = cyc;
        expd = '0;
        if (m_txn && k == m_done) begin
          expd[m_client] = 1'b1;
          if (!m_we[m_client]) m_rdata = m_cap;
        end
        checkOutput("rand_done",  done_o,  expd);
        checkOutput("rand_err",   err_o,   '0);
        checkOutput("rand_write", write_o, m_txn && k == m_issue && m_we[m_client]);
        checkOutput("rand_read",  read_o,  m_txn && k == m_issue && !m_we[m_client]);
        checkOutput("rand_rdata", rdata_o, m_rdata);
        if (m_txn && k >= m_issue && k <= m_done) begin
          checkOutput("rand_addr", addr_o, m_addr[m_client]);
          checkOutput("rand_data", data_o, m_wd[m_client]);
          checkOutput("rand_sel",  sel_o,  m_sel[m_client]);
        end

        if (m_txn && k == m_done) begin
          mreq[m_client] = 1'b0;
          m_txn       = 0;
          m_idle_from = k + 1;
        end
        for (int i = 0; i < N; i++) begin
          if (!mreq[i]) begin
            m_we[i]   = $urandom_range(0, 1);
            m_addr[i] = $urandom;
            m_wd[i]   = $urandom;
            m_sel[i]  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) mreq[i] = 1'b1;
          end
        end
        if (!m_txn && k >= m_idle_from && mreq != '0) begin
          m_client = rrPick(mreq, m_last);
          m_last   = m_client;
          m_issue  = k + 1;
          m_d0     = $urandom_range(0, 2);
          m_d1     = $urandom_range(1, 4);
          m_done   = m_issue + m_d0 + m_d1 + 2;
          m_txn    = 1;
        end

        busy_i = 1'b0;
        if (m_txn && k == m_issue) busy_i = $urandom_range(0, 1);
        if (m_txn && (k - m_issue) > m_d0 && (k - m_issue) <= m_d0 + m_d1) busy_i = 1'b1;
        data_i = $urandom;
        if (m_txn && k == m_issue + m_d0 + m_d1 + 1) m_cap = data_i;

        req_i = mreq;
        for (int i = 0; i < N; i++) setClient(i, m_we[i], m_addr[i], m_wd[i], m_sel[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
